demux_1to8_frame: RTL and testbench
===================================

DEMUX_1TO8_FRAME -- requirements
Module: demux_1to8_frame

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 i  input  1  serial data bit to be routed.
REQ-004 i_valid  input  1  i is sampled at a rising edge only when i_valid=1.
REQ-005 s  input  3  external lane select, used only when mode=1.
REQ-006 mode  input  1  0 = auto-sequenced (internal pointer); 1 = external select s.
REQ-007 clr  input  1  synchronous clear of lanes, pointer and frame register.
REQ-008 o  output  8  registered live lanes; o[k] holds the last bit routed to lane k.
REQ-009 o_strb  output  8  registered one-hot strobe; bit k high for one cycle after lane k is written.
REQ-010 frame  output  8  registered snapshot of a completed auto-mode frame.
REQ-011 frame_done  output  1  one-cycle pulse when frame is updated.
REQ-012 ptr  output  3  current auto-mode lane pointer (4 bits when DEMUX_PARITY_EN is defined).

Function
REQ-013 Accepted bit: any rising edge with i_valid=1, clr=0, rst_n=1.
REQ-014 mode=0: accepted bit written to o[ptr]; ptr increments by 1; after lane 7, ptr wraps to 0.
REQ-015 mode=1: accepted bit written to o[s]; ptr unchanged; frame and frame_done unaffected.
REQ-016 Latency: o, o_strb, frame and frame_done reflect an accepted bit in the cycle after the accepting edge (one register stage).
REQ-017 o_strb = 8'h00 in every cycle not following an accepted bit; never more than one bit set.
REQ-018 Lanes not written hold their value indefinitely.
REQ-019 Frame completion (mode=0, bit accepted at ptr=7): frame <= {i, o[6:0]}; frame_done pulses for exactly one cycle.
REQ-020 Back-to-back frames with i_valid continuously high produce frame_done every 8 cycles with no lost bit.
REQ-021 i_valid=0 gaps: ptr, o and frame hold; frame_done stays 0.
REQ-022 mode change 0->1 mid-frame: ptr is held; returning to mode=0 resumes at the held ptr; lanes written in mode=1 are overwritten by the auto sequence.
REQ-023 clr=1: o, frame, o_strb and ptr go to 0 and frame_done to 0 at the next edge; clr has priority over a simultaneous accepted bit, which is discarded.

Reset
REQ-024 rst_n=0 at a rising edge: o=8'h00, o_strb=8'h00, frame=8'h00, frame_done=0, ptr=0 (plus parity_err=0 when enabled).
REQ-025 Reset has priority over clr and i_valid; a partial frame in progress is discarded.
REQ-026 While rst_n=0, outputs remain at reset values.

Configuration
REQ-027 Macro DEMUX_PARITY_EN, when defined, adds output parity_err (1 bit) and widens ptr to 4 bits.
REQ-028 With DEMUX_PARITY_EN: auto frame is 9 accepted bits; ptr=8 takes an even-parity bit that is not written to o; completion occurs at ptr=8, ptr wraps to 0; frame <= o; parity_err <= (^o) ^ parity bit, valid while frame_done=1 and held until the next completion.
REQ-029 With DEMUX_PARITY_EN: the parity bit produces o_strb=8'h00; mode=1 behaviour is unchanged.
REQ-030 Without DEMUX_PARITY_EN: parity_err does not exist, ptr is 3 bits, and frames are 8 bits per REQ-019.

Verification
REQ-031 Reset: drive rst_n=0 for 2 cycles with i_valid=1 -> all outputs 0, ptr=0.
REQ-032 Auto frame: mode=0, bits 1,0,1,1,0,0,1,0 (lane 0 first) on consecutive cycles -> frame=8'h4D with one frame_done pulse; o_strb walks 01,02,...,80.
REQ-033 External mode: mode=1, s=5, i=1, one cycle -> o=8'h20, o_strb=8'h20 for one cycle, ptr unchanged, frame_done=0.
REQ-034 Gap and clear: 3 auto bits, i_valid low for 4 cycles, then clr=1 with i_valid=1 -> ptr=0, o=0, bit discarded, no frame_done.
REQ-035 Streaming: 16 continuous bits 0xA5 then 0x3C -> frame_done at cycles 8 and 16, frame=8'hA5 then 8'h3C.
REQ-036 Parity (DEMUX_PARITY_EN): bits of 0x0F then parity 1 -> frame=8'h0F, parity_err=1; repeat with parity 0 -> parity_err=0.

Source files
------------

// File: rtl/demux_1to8_frame.sv
// 1-to-8 serial demux with auto-sequenced framing and external lane select.
// Define DEMUX_PARITY_EN to add a 9th even-parity bit per frame and parity_err.
module demux_1to8_frame (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i,
    input  logic       i_valid,
    input  logic [2:0] s,
    input  logic       mode,
    input  logic       clr,
    output logic [7:0] o,
    output logic [7:0] o_strb,
    output logic [7:0] frame,
    output logic       frame_done,
`ifdef DEMUX_PARITY_EN
    output logic [3:0] ptr,
    output logic       parity_err
`else
    output logic [2:0] ptr
`endif
);

`ifdef DEMUX_PARITY_EN
    localparam int PW = 4;
    localparam logic [PW-1:0] LAST = 4'd8;
`else
    localparam int PW = 3;
    localparam logic [PW-1:0] LAST = 3'd7;
`endif
    localparam logic [PW-1:0] ONE = PW'(1);

    logic [7:0]    o_n;
    logic [7:0]    strb_n;
    logic [7:0]    frame_n;
    logic          done_n;
    logic [PW-1:0] ptr_n;
    logic [2:0]    lane;
    logic          perr_q;
    logic          perr_n;

    assign lane = ptr[2:0];

    always_comb begin
        o_n     = o;
        strb_n  = 8'h00;
        frame_n = frame;
        done_n  = 1'b0;
        ptr_n   = ptr;
        perr_n  = perr_q;
        if (clr) begin
            o_n     = 8'h00;
            frame_n = 8'h00;
            ptr_n   = '0;
            perr_n  = 1'b0;
        end else if (i_valid) begin
            if (mode) begin
                o_n[s]    = i;
                strb_n[s] = 1'b1;
            end else if (ptr == LAST) begin
`ifdef DEMUX_PARITY_EN
                // Parity slot: checked against the data lanes, never stored in o.
                frame_n = o;
                perr_n  = (^o) ^ i;
`else
                o_n[7]    = i;
                strb_n[7] = 1'b1;
                frame_n   = {i, o[6:0]};
`endif
                done_n = 1'b1;
                ptr_n  = '0;
            end else begin
                o_n[lane]    = i;
                strb_n[lane] = 1'b1;
                ptr_n        = ptr + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o          <= 8'h00;
            o_strb     <= 8'h00;
            frame      <= 8'h00;
            frame_done <= 1'b0;
            ptr        <= '0;
            perr_q     <= 1'b0;
        end else begin
            o          <= o_n;
            o_strb     <= strb_n;
            frame      <= frame_n;
            frame_done <= done_n;
            ptr        <= ptr_n;
            perr_q     <= perr_n;
        end
    end

`ifdef DEMUX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_demux_1to8_frame.sv
// Scoreboard bench for demux_1to8_frame: a behavioural model queues the
// expected register state per driven cycle, checked #1 after the next edge.
module tb_demux_1to8_frame;

`ifdef DEMUX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i = 1'b0;
    logic       i_valid = 1'b0;
    logic [2:0] s = 3'd0;
    logic       mode = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] o;
    logic [7:0] o_strb;
    logic [7:0] frame;
    logic       frame_done;
`ifdef DEMUX_PARITY_EN
    logic [3:0] ptr;
    logic       parity_err;
`else
    logic [2:0] ptr;
    logic       parity_err;
    assign parity_err = 1'b0;
`endif

    demux_1to8_frame dut (
        .clk(clk),
        .rst_n(rst_n),
        .i(i),
        .i_valid(i_valid),
        .s(s),
        .mode(mode),
        .clr(clr),
        .o(o),
        .o_strb(o_strb),
        .frame(frame),
        .frame_done(frame_done),
`ifdef DEMUX_PARITY_EN
        .ptr(ptr),
        .parity_err(parity_err)
`else
        .ptr(ptr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] o;
        logic [7:0] strb;
        logic [7:0] frame;
        logic       done;
        int         ptr;
        logic       perr;
    } exp_t;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail = 0;
    int   done_cnt = 0;

    logic [7:0] m_o = 8'h00;
    logic [7:0] m_strb = 8'h00;
    logic [7:0] m_frame = 8'h00;
    logic       m_done = 1'b0;
    logic       m_perr = 1'b0;
    int         m_ptr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic vi, input logic ii,
                         input logic md, input logic [2:0] ss, input logic cl);
        exp_t e;
        exp_t g;
        rst_n = rv; i_valid = vi; i = ii; mode = md; s = ss; clr = cl;
        m_strb = 8'h00;
        m_done = 1'b0;
        if (!rv || cl) begin
            m_o = 8'h00; m_frame = 8'h00; m_ptr = 0; m_perr = 1'b0;
        end else if (vi) begin
            if (md) begin
                m_o[ss] = ii;
                m_strb[ss] = 1'b1;
            end else if (PAR && m_ptr == 8) begin
                m_frame = m_o;
                m_perr = (^m_o) ^ ii;
                m_done = 1'b1;
                m_ptr = 0;
            end else begin
                m_o[m_ptr] = ii;
                m_strb[m_ptr] = 1'b1;
                if (!PAR && m_ptr == 7) begin
                    m_frame = m_o;
                    m_done = 1'b1;
                    m_ptr = 0;
                end else begin
                    m_ptr++;
                end
            end
        end
        e.o = m_o; e.strb = m_strb; e.frame = m_frame;
        e.done = m_done; e.ptr = m_ptr; e.perr = m_perr;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (frame_done) done_cnt++;
        if (q.size() == 0) begin
            chk("queue_empty", 32'd0, 32'd1);
        end else begin
            g = q.pop_front();
            chk("o", {24'd0, o}, {24'd0, g.o});
            chk("o_strb", {24'd0, o_strb}, {24'd0, g.strb});
            chk("frame", {24'd0, frame}, {24'd0, g.frame});
            chk("frame_done", {31'd0, frame_done}, {31'd0, g.done});
            chk("ptr", 32'(ptr), 32'(g.ptr));
            chk("parity_err", {31'd0, parity_err}, {31'd0, g.perr});
        end
    endtask

    task automatic auto_bit(input logic b);
        drive(1'b1, 1'b1, b, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic do_clr();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
    endtask

    initial begin
        logic [7:0] pat;
        // Reset with valid data present.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        chk("rst_o", {24'd0, o}, 32'h0);
        chk("rst_ptr", 32'(ptr), 32'd0);

        // Auto frame: lane 0 first.
        pat = 8'h4D;
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            auto_bit(pat[k]);
            chk("strb_walk", {24'd0, o_strb}, 32'(8'h01 << k));
        end
`ifndef DEMUX_PARITY_EN
        chk("frame_4d", {24'd0, frame}, 32'h4D);
        chk("done_once", 32'(done_cnt), 32'd1);
`else
        auto_bit(1'b0);
`endif
        idle();

        // External select.
        do_clr();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0);
        chk("ext_o", {24'd0, o}, 32'h20);
        chk("ext_strb", {24'd0, o_strb}, 32'h20);
        idle();

        // Gap then clear with a competing valid bit.
        for (int k = 0; k < 3; k++) auto_bit(1'b1);
        for (int k = 0; k < 4; k++) idle();
        chk("gap_ptr", 32'(ptr), 32'd3);
        do_clr();
        chk("clr_ptr", 32'(ptr), 32'd0);
        chk("clr_o", {24'd0, o}, 32'h0);

        // Mode switch mid-frame; lane 6 written externally then overwritten.
        for (int k = 0; k < 3; k++) auto_bit(1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd6, 1'b0);
        for (int k = 0; k < 5; k++) auto_bit(1'b0);
`ifndef DEMUX_PARITY_EN
        chk("mode_frame", {24'd0, frame}, 32'h07);
`else
        auto_bit(1'b1);
`endif

        // Streaming back-to-back frames.
        do_clr();
        for (int f = 0; f < 2; f++) begin
            pat = (f == 0) ? 8'hA5 : 8'h3C;
            for (int k = 0; k < 8; k++) auto_bit(pat[k]);
`ifndef DEMUX_PARITY_EN
            chk("stream_done", {31'd0, frame_done}, 32'd1);
            chk("stream_frame", {24'd0, frame}, {24'd0, pat});
`else
            auto_bit(^pat);
            chk("stream_frame", {24'd0, frame}, {24'd0, pat});
`endif
        end

`ifdef DEMUX_PARITY_EN
        do_clr();
        for (int p = 0; p < 2; p++) begin
            pat = 8'h0F;
            for (int k = 0; k < 8; k++) auto_bit(pat[k]);
            auto_bit(p == 0);
            chk("par_frame", {24'd0, frame}, 32'h0F);
            chk("par_err", {31'd0, parity_err}, (p == 0) ? 32'd1 : 32'd0);
        end
`endif

        // Reset discards a partial frame, overriding clr and valid.
        for (int k = 0; k < 4; k++) auto_bit(1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
        chk("rst_mid_ptr", 32'(ptr), 32'd0);

        // Random mix.
        for (int k = 0; k < 60; k++) begin
            drive($urandom_range(0, 31) != 0, $urandom_range(0, 3) != 0,
                  1'($urandom), $urandom_range(0, 7) == 0,
                  3'($urandom), $urandom_range(0, 19) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
